// File: rtl/ui_pkg.sv
// Shared types and widths for the UI digit scan sequencer.
package ui_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DWELL = 2'd1,
        BLANK = 2'd2
    } scan_state_t;

    localparam int unsigned DIGIT_W = 5;
    localparam int unsigned SLOW_W  = 32;

endpackage

// File: rtl/ui_term_counter.sv
// Enable/clear up-counter over 0..BOUND-1 with a terminal-count flag; wraps to 0
// when enabled on the terminal count.
module ui_term_counter #(
    parameter int unsigned BOUND = 2
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic term
);

    localparam int unsigned CW = (BOUND > 1) ? $clog2(BOUND) : 1;
    localparam logic [CW-1:0] TERM_VAL = CW'(BOUND - 1);

    logic [CW-1:0] count_reg;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable) begin
            count_reg <= term ? '0 : count_reg + CW'(1);
        end
    end

    assign term = (count_reg == TERM_VAL);

endmodule

// File: rtl/ui_digit_scan.sv
// Display multiplex sequencer: steps the digit index with a fixed dwell, optional
// inter-digit blanking (build with UI_SCAN_BLANK_EN), and a frame-based slow tick.
module ui_digit_scan
    import ui_pkg::*;
#(
    parameter int unsigned NUM_DIGITS      = 32,
    parameter int unsigned DWELL_CYCLES    = 1000,
    parameter int unsigned BLANK_CYCLES    = 50,
    parameter int unsigned FRAMES_PER_TICK = 64
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               scan_enable,
    output logic [DIGIT_W-1:0] digit_in,
    output logic               scan_active,
    output logic               frame_start,
    output logic [SLOW_W-1:0]  slow_clock
);

    localparam logic [DIGIT_W-1:0] LAST_DIGIT = DIGIT_W'(NUM_DIGITS - 1);

    scan_state_t        state_reg;
    logic [DIGIT_W-1:0] digit_reg;
    logic               active_reg;
    logic               frame_start_reg;
    logic [SLOW_W-1:0]  slow_clock_reg;

    logic               in_dwell;
    logic               dwell_term;
    logic               advance;
    logic               last_digit;
    logic               frame_tick;
    logic               frame_term;
    logic [DIGIT_W-1:0] digit_next;

    assign in_dwell   = (state_reg == DWELL);
    assign last_digit = (digit_reg == LAST_DIGIT);
    assign digit_next = last_digit ? '0 : digit_reg + DIGIT_W'(1);

    ui_term_counter #(.BOUND(DWELL_CYCLES)) u_dwell (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (!scan_enable || !in_dwell),
        .enable  (in_dwell),
        .term    (dwell_term)
    );

`ifdef UI_SCAN_BLANK_EN
    logic in_blank;
    logic blank_term;

    assign in_blank = (state_reg == BLANK);

    ui_term_counter #(.BOUND(BLANK_CYCLES)) u_blank (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (!scan_enable || !in_blank),
        .enable  (in_blank),
        .term    (blank_term)
    );

    assign advance = scan_enable && in_blank && blank_term;
`else
    // Gap length only matters when blanking is built in.
    logic blank_unused;
    assign blank_unused = (BLANK_CYCLES == 0);

    assign advance = scan_enable && in_dwell && dwell_term;
`endif

    // A frame completes when the last digit hands over to digit 0.
    assign frame_tick = advance && last_digit;

    ui_term_counter #(.BOUND(FRAMES_PER_TICK)) u_frame (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (!scan_enable),
        .enable  (frame_tick),
        .term    (frame_term)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= IDLE;
            digit_reg       <= '0;
            active_reg      <= 1'b0;
            frame_start_reg <= 1'b0;
            slow_clock_reg  <= '0;
        end else if (!scan_enable) begin
            // Blink phase in slow_clock survives a scan stop.
            state_reg       <= IDLE;
            digit_reg       <= '0;
            active_reg      <= 1'b0;
            frame_start_reg <= 1'b0;
        end else begin
            frame_start_reg <= 1'b0;
            if (frame_tick && frame_term) begin
                slow_clock_reg <= slow_clock_reg + SLOW_W'(1);
            end
            case (state_reg)
                IDLE: begin
                    state_reg       <= DWELL;
                    digit_reg       <= '0;
                    active_reg      <= 1'b1;
                    frame_start_reg <= 1'b1;
                end
                DWELL: begin
                    if (dwell_term) begin
`ifdef UI_SCAN_BLANK_EN
                        state_reg  <= BLANK;
                        active_reg <= 1'b0;
`else
                        digit_reg       <= digit_next;
                        frame_start_reg <= last_digit;
`endif
                    end
                end
`ifdef UI_SCAN_BLANK_EN
                BLANK: begin
                    if (blank_term) begin
                        state_reg       <= DWELL;
                        active_reg      <= 1'b1;
                        digit_reg       <= digit_next;
                        frame_start_reg <= last_digit;
                    end
                end
`endif
                default: begin
                    state_reg  <= IDLE;
                    digit_reg  <= '0;
                    active_reg <= 1'b0;
                end
            endcase
        end
    end

    assign digit_in    = digit_reg;
    assign scan_active = active_reg;
    assign frame_start = frame_start_reg;
    assign slow_clock  = slow_clock_reg;

endmodule
